score_display_driver: RTL
=========================

// Module: score_display_driver
// PURPOSE
// - Consumer of the two BCD score digits (ones, tens) produced by the score counter.
// - Time-multiplexes the digits onto a 4-digit, common-anode seven-segment display.
// - Frame-boundary digit shadowing prevents a mid-frame score change from tearing the display.
// - On each rising edge of the score pulse, the block flashes (blinks) the display for a fixed
//   number of frames.
// PARAMETERS
// - REFRESH_DIV  50000  clocks per digit slot; must be >=2
// - BLANK_LZ     1      1 = blank the tens digit when it is 0
// - FLASH_HALF   64     frames per blink half-period (on or off)
// - FLASH_BLINKS 3      number of off/on blink pairs per flash
// PORTS
// - clk       in   1  system clock
// - rst       in   1  asynchronous, active-high reset
// - score     in   1  score pulse; level, synchronous to clk; the rising edge triggers a flash
// - digit0    in   4  BCD ones digit
// - digit1    in   4  BCD tens digit
// - seg       out  7  {g,f,e,d,c,b,a}, active low
// - dp        out  1  decimal point, active low; always 1 (off)
// - an        out  4  anode enables, active low; an[0] = ones digit
// - flashing  out  1  high while the flash FSM is not IDLE
// BEHAVIOUR
// - Reset (async) values: seg=7'h7F, an=4'hF, dp=1, flashing=0.
//   Internal reset values: refresh cnt=0, slot=0, shadow digits=0, FSM=IDLE.
// - Refresh counter:
//   - Counts 0..REFRESH_DIV-1, then wraps to 0.
//   - On the terminal count, slot advances 0->1->2->3->0.
//   - Frame = 4*REFRESH_DIV clocks; frame_tick = terminal count while slot==3.
// - Shadow digits: digit0/digit1 load into shadow registers only on frame_tick.
//   Displayed values therefore change only at the start of slot 0.
// - seg, an: registered; each updates exactly 1 clk after the slot changes.
//   - Slot 0: an=4'b1110, shows the ones shadow.
//   - Slot 1: an=4'b1101, shows the tens shadow. If BLANK_LZ=1 and tens==0: an=4'b1111, seg=7'h7F.
//   - Slots 2, 3: an=4'b1111, seg=7'h7F (unused digits, kept dark for equal duty).
// - Decode values:
//   - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex).
//   - Non-BCD 10..15 -> 3F (dash, g only).
// - Score edge detect: score is registered; rise = score & ~score_q. A held-high score counts as one edge.
// - Flash FSM:
//   - States IDLE, OFF, ON. A frame counter counts frames in the current half; a blink counter counts blinks.
//   - IDLE --rise--> OFF (counters cleared).
//   - OFF --FLASH_HALF frames--> ON.
//   - ON --FLASH_HALF frames--> OFF if blinks < FLASH_BLINKS-1 (blink counter incremented), else IDLE.
//   - In OFF, an is forced to 4'hF and seg to 7'h7F. Refresh and shadowing continue unaffected.
//   - A rise while in OFF or ON restarts the flash at OFF with counters cleared (retrigger).
//   - flashing = (state != IDLE), registered.
// - A rise that coincides with frame_tick: both take effect. Shadows load; FSM enters OFF.
// - A digit change and a score rise in the same cycle are independent.
// - Reset mid-flash or mid-frame: all state returns immediately to the reset values; no partial frame resumes.
// TESTING (bench uses REFRESH_DIV=4, FLASH_HALF=2, FLASH_BLINKS=2; frame = 16 clk)
// - Reset release, digit1=0, digit0=0, BLANK_LZ=1 -> first frame:
//   an=1110, seg=40 for 4 clk, then an=1111 for 12 clk. Before rst deasserts: seg=7F, an=F.
// - digit1=4, digit0=7 applied mid-slot 1 -> old shadow shown until frame end.
//   Next frame: slot0 seg=78 an=1110, slot1 seg=19 an=1101.
// - digit0=4'hC -> after the next frame_tick, slot0 seg=3F (dash).
// - score 0->1 held for 10 clk -> exactly one flash; flashing=1 for 2*2*2 frames = 128 clk.
//   an=F during each OFF half; then IDLE, flashing=0.
// - Second score rise 40 clk into a flash -> FSM returns to OFF; flashing stays high for a further 128 clk.
// - rst asserted asynchronously while in ON mid-slot -> seg=7F, an=F, flashing=0 in the same cycle.
//   After release, scan restarts at slot 0.

Source files
------------

// File: rtl/score_display_driver.sv
// Multiplexes two BCD score digits onto a 4-digit common-anode display.
// Shadows digits at frame boundaries and blinks the display on each score rise.
module score_display_driver #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_LZ     = 1,
  parameter int FLASH_HALF   = 64,
  parameter int FLASH_BLINKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       score,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       flashing
);

  localparam int FRAME = 4 * REFRESH_DIV;
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int FW = $clog2(FRAME);
  localparam int HW = $clog2(FLASH_HALF + 1);
  localparam int BW = $clog2(FLASH_BLINKS + 1);

  typedef enum logic [1:0] {IDLE, OFF, ON} state_e;

  logic [CW-1:0] cnt_q;
  logic [1:0]    slot_q;
  logic [3:0]    sh0_q, sh1_q;
  logic          score_q;
  state_e        state_q;
  logic [FW-1:0] fclk_q;
  logic [HW-1:0] fcnt_q;
  logic [BW-1:0] blink_q;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          flash_q;

  logic tc, frame_tick, rise, frame_end, half_end;

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0:    dec = 7'h40;
      4'd1:    dec = 7'h79;
      4'd2:    dec = 7'h24;
      4'd3:    dec = 7'h30;
      4'd4:    dec = 7'h19;
      4'd5:    dec = 7'h12;
      4'd6:    dec = 7'h02;
      4'd7:    dec = 7'h78;
      4'd8:    dec = 7'h00;
      4'd9:    dec = 7'h10;
      default: dec = 7'h3F;
    endcase
  endfunction

  always_comb begin
    tc         = (cnt_q == CW'(REFRESH_DIV - 1));
    frame_tick = tc && (slot_q == 2'd3);
    rise       = score && !score_q;
    // Flash halves are timed from the flash start, not from display frames
    frame_end  = (fclk_q == FW'(FRAME - 1));
    half_end   = frame_end && (fcnt_q == HW'(FLASH_HALF - 1));
  end

  always_comb begin
    seg_d = 7'h7F;
    an_d  = 4'hF;
    case (slot_q)
      2'd0: begin
        seg_d = dec(sh0_q);
        an_d  = 4'b1110;
      end
      2'd1: begin
        if (!(BLANK_LZ != 0 && sh1_q == 4'd0)) begin
          seg_d = dec(sh1_q);
          an_d  = 4'b1101;
        end
      end
      default: ;
    endcase
    if (state_q == OFF) begin
      seg_d = 7'h7F;
      an_d  = 4'hF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      slot_q  <= '0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      score_q <= 1'b0;
      seg_q   <= 7'h7F;
      an_q    <= 4'hF;
    end else begin
      cnt_q   <= tc ? '0 : cnt_q + 1'b1;
      score_q <= score;
      seg_q   <= seg_d;
      an_q    <= an_d;
      if (tc) slot_q <= slot_q + 2'd1;
      if (frame_tick) begin
        sh0_q <= digit0;
        sh1_q <= digit1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fclk_q  <= '0;
      fcnt_q  <= '0;
      blink_q <= '0;
      flash_q <= 1'b0;
    end else if (rise) begin
      state_q <= OFF;
      fclk_q  <= '0;
      fcnt_q  <= '0;
      blink_q <= '0;
      flash_q <= 1'b1;
    end else if (state_q != IDLE) begin
      fclk_q <= frame_end ? '0 : fclk_q + 1'b1;
      if (frame_end) fcnt_q <= fcnt_q + 1'b1;
      if (half_end) begin
        fcnt_q <= '0;
        if (state_q == OFF) begin
          state_q <= ON;
        end else if (blink_q < BW'(FLASH_BLINKS - 1)) begin
          state_q <= OFF;
          blink_q <= blink_q + 1'b1;
        end else begin
          state_q <= IDLE;
          flash_q <= 1'b0;
        end
      end
    end
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign dp       = 1'b1;
  assign flashing = flash_q;

endmodule
